ps_window_accum: RTL

Downstream consumer of the per-sample power (squaring) stage. It sums squared samples over a fixed window of WIN_LEN valid samples and emits the window energy, the mean power and a threshold flag. Windows run back-to-back with no dead cycles. Its output feeds the detection / feature-extraction stage.

---
 rtl/ps_window_accum_pkg.sv | 19 +
 rtl/ps_window_accum_if.sv | 30 +++
 rtl/ps_window_accum.sv | 93 +++++++++
 3 files changed

// File: rtl/ps_window_accum_pkg.sv
// Shared definitions for the power-stage window accumulator and its neighbours.
// Widths match the squaring stage that feeds this block.
package ps_pkg;

  localparam int PS_DATA_WIDTH = 32;
  localparam int PS_IN_WIDTH   = 16;
  localparam int PS_LOG2_WIN   = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } ps_acc_state_t;

  // A window of one sample still needs a 1-bit counter so the vector stays legal.
  function automatic int ps_cnt_width(input int log2_win);
    return (log2_win > 0) ? log2_win : 1;
  endfunction

endpackage

// File: rtl/ps_window_accum_if.sv
// Sample stream in, window statistics out, for the power-stage window accumulator.
// master drives samples and reads results; slave is the accumulator itself.
interface ps_window_accum_if
  import ps_pkg::*;
#(
  parameter int DATA_WIDTH = PS_DATA_WIDTH,
  parameter int ACC_WIDTH  = PS_DATA_WIDTH + PS_LOG2_WIN
);

  logic                  clr;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] threshold;
  logic [ACC_WIDTH-1:0]  sum_out;
  logic [DATA_WIDTH-1:0] mean_out;
  logic                  out_valid;
  logic                  above_thr;
  logic [15:0]           win_cnt;

  modport master (
    output clr, in_valid, din, threshold,
    input  sum_out, mean_out, out_valid, above_thr, win_cnt
  );

  modport slave (
    input  clr, in_valid, din, threshold,
    output sum_out, mean_out, out_valid, above_thr, win_cnt
  );

endinterface

// File: rtl/ps_window_accum.sv
// Sums squared samples over back-to-back windows of 2**LOG2_WIN valid samples and
// reports window energy, mean power and a threshold flag once per window.
module ps_window_accum
  import ps_pkg::*;
#(
  parameter int DATA_WIDTH = PS_DATA_WIDTH,
  parameter int LOG2_WIN   = PS_LOG2_WIN,
  parameter int ACC_WIDTH  = DATA_WIDTH + LOG2_WIN,
  parameter int ALIGN_DLY  = 1
) (
  input logic             clk,
  input logic             rst,
  ps_window_accum_if.slave bus
);

  localparam int              CNT_W    = ps_cnt_width(LOG2_WIN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((64'd1 << LOG2_WIN) - 64'd1);
  localparam bit              SINGLE   = (LOG2_WIN == 0);

  logic                  v_al;
  ps_acc_state_t         state;
  logic [ACC_WIDTH-1:0]  acc;
  logic [CNT_W-1:0]      cnt;
  logic [ACC_WIDTH-1:0]  sum_next;
  logic [DATA_WIDTH-1:0] mean_next;
  logic                  last;

  // Upstream raises valid when it captures a sample; the square shows up a cycle later.
  generate
    if (ALIGN_DLY == 1) begin : g_align
      logic v_al_q;

      always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
          v_al_q <= 1'b0;
        end else begin
          v_al_q <= bus.in_valid;
        end
      end

      assign v_al = v_al_q;
    end else begin : g_no_align
      assign v_al = bus.in_valid;
    end
  endgenerate

  assign sum_next  = acc + ACC_WIDTH'(bus.din);
  assign mean_next = DATA_WIDTH'(sum_next >> LOG2_WIN);
  assign last      = v_al && (SINGLE ? (state == IDLE)
                                     : (state == ACCUM && cnt == LAST_CNT));

  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else if (v_al) begin
      if (last) begin
        state <= IDLE;
        acc   <= '0;
        cnt   <= '0;
      end else if (state == IDLE) begin
        state <= ACCUM;
        acc   <= ACC_WIDTH'(bus.din);
        cnt   <= CNT_W'(1);
      end else begin
        acc <= sum_next;
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Results only move on the final sample of a window; clr suppresses the emit.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.sum_out   <= '0;
      bus.mean_out  <= '0;
      bus.above_thr <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.win_cnt   <= '0;
    end else begin
      bus.out_valid <= 1'b0;
      if (!bus.clr && last) begin
        bus.sum_out   <= sum_next;
        bus.mean_out  <= mean_next;
        bus.above_thr <= (mean_next > bus.threshold);
        bus.out_valid <= 1'b1;
        bus.win_cnt   <= bus.win_cnt + 16'd1;
      end
    end
  end

endmodule
